fsm_seq_match_mo_param: RTL and testbench



---
 rtl/fsm_seq_match_mo_param.sv | 111 +++++++++++
 tb/tb_fsm_seq_match_mo_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_match_mo_param.sv
// rtl/fsm_seq_match_mo_param.sv - registered Moore detector for a loadable NSYMS-symbol pattern
// Optional saturating match counter built only when SEQ_MATCH_COUNT_EN is defined.
module fsm_seq_match_mo_param #(
    parameter int NBITS = 2,
    parameter int NSYMS = 3,
    parameter int PW    = $clog2(NSYMS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NBITS-1:0]       in_,
    input  logic                   load,
    input  logic [NSYMS*NBITS-1:0] pattern_in,
    input  logic                   clear,
    output logic                   match,
    output logic [PW-1:0]          progress,
    output logic [7:0]             match_count
);

    typedef enum logic [1:0] {
        IDLE,
        PART,
        MATCH
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PW-1:0]            depth;
    logic [PW-1:0]            depth_next;
    logic [PW-1:0]            base;
    logic [NSYMS*NBITS-1:0]   pat;
    logic [NBITS-1:0]         cur_sym;
    logic [NBITS-1:0]         first_sym;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            depth <= '0;
            pat   <= '0;
        end else begin
            if (load) begin
                pat <= pattern_in;
            end
            state <= state_next;
            depth <= depth_next;
        end
    end

    // MATCH restarts from progress 0, so the next symbol is compared against symbol 0.
    always_comb begin
        state_next = state;
        depth_next = depth;
        base       = (state == MATCH) ? '0 : depth;
        first_sym  = pat[NBITS-1:0];
        cur_sym    = first_sym;
        for (int k = 0; k < NSYMS; k++) begin
            if (base == PW'(k)) begin
                cur_sym = pat[k*NBITS +: NBITS];
            end
        end

        if (load) begin
            state_next = IDLE;
            depth_next = '0;
        end else if (en) begin
            if (in_ == cur_sym) begin
                if (base == PW'(NSYMS - 1)) begin
                    state_next = MATCH;
                    depth_next = PW'(NSYMS);
                end else begin
                    state_next = PART;
                    depth_next = base + PW'(1);
                end
            end else if (in_ == first_sym) begin
                state_next = PART;
                depth_next = PW'(1);
            end else begin
                state_next = IDLE;
                depth_next = '0;
            end
        end
    end

    assign match    = (state == MATCH);
    assign progress = depth;

`ifdef SEQ_MATCH_COUNT_EN
    logic [7:0] count;
    logic       enter_match;

    assign enter_match = (state != MATCH) && (state_next == MATCH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 8'h00;
        end else if (clear) begin
            count <= 8'h00;
        end else if (enter_match && (count != 8'hFF)) begin
            count <= count + 8'h01;
        end
    end

    assign match_count = count;
`else
    logic unused_clear;

    assign unused_clear = clear;
    assign match_count  = 8'h00;
`endif

endmodule

// File: tb/tb_fsm_seq_match_mo_param.sv
// tb/tb_fsm_seq_match_mo_param.sv - directed and random checks of fsm_seq_match_mo_param
// Expected match_count follows SEQ_MATCH_COUNT_EN as seen by this compile.
module tb_fsm_seq_match_mo_param;

    localparam int NB = 2;
    localparam int NS = 3;
    localparam int PWL = $clog2(NS + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [NB-1:0]    in_;
    logic             load;
    logic [NS*NB-1:0] pattern_in;
    logic             clear;
    logic             match;
    logic [PWL-1:0]   progress;
    logic [7:0]       match_count;

    int vectors = 0;
    int miscompares = 0;

    int pat_v = 0;
    int prog_m = 0;
    int cnt_m = 0;

    fsm_seq_match_mo_param #(.NBITS(NB), .NSYMS(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .in_         (in_),
        .load        (load),
        .pattern_in  (pattern_in),
        .clear       (clear),
        .match       (match),
        .progress    (progress),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    function automatic int sym_of(input int pv, input int k);
        return (pv >> (k * NB)) & ((1 << NB) - 1);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit e, input int d,
                              input int pin, input bit c);
        bit entered;
        int b;
        entered = 1'b0;
        if (!r) begin
            pat_v  = 0;
            prog_m = 0;
            cnt_m  = 0;
        end else begin
            if (l) begin
                pat_v  = pin;
                prog_m = 0;
            end else if (e) begin
                b = (prog_m == NS) ? 0 : prog_m;
                if (d == sym_of(pat_v, b)) prog_m = b + 1;
                else if (d == sym_of(pat_v, 0)) prog_m = 1;
                else prog_m = 0;
                entered = (prog_m == NS);
            end
            if (c) cnt_m = 0;
            else if (entered && cnt_m < 255) cnt_m = cnt_m + 1;
        end
    endtask

    function automatic int exp_count();
`ifdef SEQ_MATCH_COUNT_EN
        return cnt_m;
`else
        return 0;
`endif
    endfunction

    task automatic cycle(input bit r, input bit l, input bit e, input int d,
                         input int pin, input bit c);
        reset      = r;
        load       = l;
        en         = e;
        in_        = d[NB-1:0];
        pattern_in = pin[NS*NB-1:0];
        clear      = c;
        @(posedge clk);
        model_step(r, l, e, d, pin, c);
        #1;
        check("match", int'(match), int'(prog_m == NS));
        check("progress", int'(progress), prog_m);
        check("match_count", int'(match_count), exp_count());
    endtask

    task automatic beat(input int d);
        cycle(1'b1, 1'b0, 1'b1, d, 0, 1'b0);
    endtask

    task automatic hold(input int d);
        cycle(1'b1, 1'b0, 1'b0, d, 0, 1'b0);
    endtask

    task automatic load_pat(input int pin);
        cycle(1'b1, 1'b1, 1'b0, 0, pin, 1'b0);
    endtask

    initial begin
        cycle(1'b0, 1'b1, 1'b1, 1, 'h2D, 1'b1);
        check("reset_match", int'(match), 0);
        check("reset_progress", int'(progress), 0);

        // basic match and leave
        load_pat('h2D);
        beat(1); beat(3); beat(2);
        check("basic_match", int'(match), 1);
        beat(0);
        check("basic_leave", int'(match), 0);

        // restart on mismatch
        beat(1); beat(1); beat(3); beat(2);
        beat(1); beat(3); beat(3);
        check("restart_zero", int'(progress), 0);
        load_pat('h10);
        beat(0); beat(0); beat(0); beat(1);
        check("no_overlap", int'(match), 0);

        // valid gating
        load_pat('h2D);
        beat(1);
        for (int i = 0; i < 4; i++) hold($urandom_range(0, 3));
        check("gated_hold", int'(progress), 1);
        beat(3); beat(2);
        for (int i = 0; i < 3; i++) hold($urandom_range(0, 3));
        check("match_hold", int'(match), 1);

        // load and reset mid-sequence
        beat(1); beat(3);
        cycle(1'b1, 1'b1, 1'b1, 2, 'h2D, 1'b0);
        check("load_idle", int'(progress), 0);
        beat(1); beat(3);
        cycle(1'b0, 1'b0, 1'b1, 2, 0, 1'b0);
        beat(0); beat(0); beat(0);
        check("zero_pattern", int'(match), 1);

        // counter saturation and clear priority
        load_pat('h2D);
        for (int i = 0; i < 256; i++) begin
            beat(1); beat(3); beat(2);
        end
`ifdef SEQ_MATCH_COUNT_EN
        check("saturate", int'(match_count), 255);
`else
        check("count_tied", int'(match_count), 0);
`endif
        beat(1); beat(3);
        cycle(1'b1, 1'b0, 1'b1, 2, 0, 1'b1);
        check("clear_wins", int'(match_count), 0);
        beat(1); beat(3); beat(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int pin;
            pin = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 'h2D;
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                              : sym_of(pat_v, prog_m % NS),
                  pin, ($urandom_range(0, 59) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
